// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - PWM generator driven by t_high/t_low tick counts.
// Duty words are shadowed at period boundaries so the output never glitches mid-period.
module pwm_gen #(
    parameter int width    = 5,
    parameter int prescale = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [width-1:0] t_high,
    input  logic [width-1:0] t_low,
    output logic             pwm_out,
    output logic             period_end,
    output logic             busy
);

    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_HIGH   = 2'd1;
    localparam logic [1:0]       S_LOW    = 2'd2;
    localparam logic [15:0]      PRE_LAST = 16'(prescale - 1);
    localparam logic [width-1:0] CNT_ONE  = {{(width-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [width-1:0] r_sh_high;
    logic [width-1:0] r_sh_low;
    logic [width-1:0] r_cnt;
    logic [15:0]      r_pre;
    logic             r_pwm;
    logic             r_pend;
    logic             r_busy;

    logic [1:0]       w_state_nx;
    logic [width-1:0] w_sh_high_nx;
    logic [width-1:0] w_sh_low_nx;
    logic [width-1:0] w_cnt_nx;
    logic [15:0]      w_pre_nx;
    logic             w_tick;
    logic             w_load;
    logic             w_pend;

    always_comb begin
        w_tick       = (r_pre == PRE_LAST);
        w_state_nx   = r_state;
        w_sh_high_nx = r_sh_high;
        w_sh_low_nx  = r_sh_low;
        w_cnt_nx     = r_cnt;
        w_pre_nx     = r_pre;
        w_load       = 1'b0;
        w_pend       = 1'b0;

        case (r_state)
            S_IDLE: w_load = enable;
            S_HIGH, S_LOW: begin
                if (!enable) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_pre_nx = w_tick ? 16'd0 : r_pre + 16'd1;
                    if (w_tick) begin
                        if (r_cnt > CNT_ONE) begin
                            w_cnt_nx = r_cnt - CNT_ONE;
                        end else if (r_state == S_HIGH && r_sh_low != '0) begin
                            w_state_nx = S_LOW;
                            w_cnt_nx   = r_sh_low;
                        end else begin
                            w_pend = 1'b1;
                            w_load = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Load takes the live inputs, so a boundary flows straight into the next period.
        if (w_load) begin
            w_sh_high_nx = t_high;
            w_sh_low_nx  = t_low;
            w_pre_nx     = 16'd0;
            if (t_high != '0) begin
                w_state_nx = S_HIGH;
                w_cnt_nx   = t_high;
            end else if (t_low != '0) begin
                w_state_nx = S_LOW;
                w_cnt_nx   = t_low;
            end else begin
                w_state_nx = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sh_high <= '0;
            r_sh_low  <= '0;
            r_cnt     <= '0;
            r_pre     <= 16'd0;
            r_pwm     <= 1'b0;
            r_pend    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sh_high <= w_sh_high_nx;
            r_sh_low  <= w_sh_low_nx;
            r_cnt     <= w_cnt_nx;
            r_pre     <= w_pre_nx;
            r_pwm     <= (w_state_nx == S_HIGH);
            r_pend    <= w_pend;
            r_busy    <= (w_state_nx != S_IDLE);
        end
    end

    assign pwm_out    = r_pwm;
    assign period_end = r_pend;
    assign busy       = r_busy;

endmodule

// File: doc/pwm_gen.md
# pwm_gen

Consumes the `t_high` / `t_low` duty-cycle words produced by the push-button duty-cycle controller and drives a single PWM output pin. The waveform is high for `t_high` ticks and low for `t_low` ticks, where one tick is `prescale` clock cycles. Duty words are captured into shadow registers only at period boundaries, so the waveform never glitches when the buttons change the words mid-period. The block sits between the duty-cycle controller and the board output (LED / motor driver).

## Interface
- `width`, 5, width of `t_high`, `t_low` and the internal phase counter.
- `prescale`, 4, clock cycles per tick; legal range 1..65535; the prescaler counter is 16 bits.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; 0 forces idle with the output low.
- `t_high`  in  width  high-phase length in ticks (unsigned).
- `t_low`  in  width  low-phase length in ticks (unsigned).
- `pwm_out`  out  1  registered PWM waveform.
- `period_end`  out  1  registered one-cycle pulse marking a period boundary.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- State machine: IDLE, HIGH, LOW. Registers:
  - `sh_high`, `sh_low`: shadow registers, width bits.
  - `cnt`: phase counter, width bits.
  - `pre`: prescaler, 16 bits.
- Reset (when `reset`=1, checked before anything else): state IDLE; `pwm_out`=0; `period_end`=0; `busy`=0; `sh_high`, `sh_low`, `cnt` and `pre` all 0.
- Load rule (applied on leaving IDLE and at every period end):
  - Capture `sh_high`=`t_high` and `sh_low`=`t_low`.
  - If `t_high`≠0: go to HIGH with `cnt`=`t_high`.
  - Else if `t_low`≠0: go to LOW with `cnt`=`t_low`.
  - Else (both 0): go to IDLE.
  - `pre` is cleared to 0 on every load.
- IDLE:
  - `pwm_out`=0.
  - If `enable`=1, apply the load rule on the same edge.
  - Entering a period from IDLE does not pulse `period_end`.
- Tick generation:
  - In HIGH or LOW, `pre` increments every cycle.
  - tick = (`pre` == `prescale`-1). On a tick, `pre` wraps to 0.
- HIGH:
  - `pwm_out`=1.
  - On a tick with `cnt`>1: decrement `cnt`.
  - On a tick with `cnt`==1:
    - If `sh_low`≠0: go to LOW with `cnt`=`sh_low`.
    - Else: period end.
- LOW:
  - `pwm_out`=0.
  - On a tick with `cnt`>1: decrement `cnt`.
  - On a tick with `cnt`==1: period end.
- Period end: `period_end`=1 for exactly one cycle, then apply the load rule with the current inputs.
- `enable`=0 in HIGH or LOW aborts the period:
  - Next edge: IDLE with `pwm_out`=0.
  - No `period_end` pulse.
  - Shadow registers are kept.
- Reset mid-period has the same effect as reset from power-up. Reset takes priority over `enable`.
- `t_high` / `t_low` changes during a period are ignored until the next load.
- No arithmetic overflow is possible: `cnt` only decrements from a nonzero value down to 1, then reloads.

## Timing
- `pwm_out`, `period_end` and `busy` are registers that change on the same edge as the state.
- `enable` sampled 1 at edge E0 with `t_high`≠0: `pwm_out`=1 starting in the cycle after E0.
- HIGH lasts exactly `sh_high`×`prescale` cycles. LOW lasts exactly `sh_low`×`prescale` cycles.
- Period = (`sh_high`+`sh_low`)×`prescale` cycles, with no idle gap between periods.
- `period_end` is high during the first cycle of the following period. This is the same cycle in which the newly loaded shadows take effect.
- Both words 0 at a boundary:
  - `period_end` pulses and the state returns to IDLE.
  - If `enable`=1, the block reloads on the next edge (the inputs are polled every cycle).
- `t_low`=0: the output stays continuously high; `period_end` pulses every `sh_high`×`prescale` cycles.
- `t_high`=0: the output stays continuously low; `period_end` pulses every `sh_low`×`prescale` cycles.

## Test plan
- `prescale`=1, `t_high`=8, `t_low`=12, `enable`=1 -> repeated 20-cycle periods: 8 cycles high, then 12 low; `period_end` pulses every 20 cycles.
- `prescale`=4, `t_high`=3, `t_low`=2 -> high 12 cycles, low 8 cycles, period 20; `busy`=1 throughout.
- `t_high` changed 10→11 midway through a HIGH phase -> current period keeps 10 ticks high; the next period is 11 high and `t_low` low.
- `t_low`=0, `t_high`=5, `prescale`=1 -> `pwm_out` constantly 1, `period_end` every 5 cycles. Then both words set to 0 -> IDLE after the boundary, `pwm_out`=0, `busy`=0.
- `enable` dropped in the 3rd cycle of HIGH -> next cycle: `pwm_out`=0, `busy`=0, no `period_end`. `enable` reasserted -> fresh full-length period.
- `reset`=1 asserted mid-LOW while `enable`=1 -> next cycle all outputs 0 and state IDLE. After `reset` is released, the block reloads from the inputs on the first edge.
